// File: rtl/ether_pkg.sv
// Shared constants and types for the GMII transmit path.
// Build option: define ETHER_TX_PAD_EN to pad short frames to the minimum length.
package ether_pkg;

    // Preamble and start-of-frame delimiter bytes
    localparam logic [7:0]  PREAMBLE           = 8'h55;
    localparam logic [7:0]  SFD                = 8'hD5;

    // Ethernet CRC-32, bit-reversed form, shifted LSB first
    localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB88320;
    // Register value left after running a frame plus its own FCS through the CRC
    localparam logic [31:0] CRC32_RESIDUE_REFL = 32'hDEBB20E3;

    // Default frame geometry, in bytes
    localparam int MIN_FRAME_DEF = 60;
    localparam int MAX_FRAME_DEF = 1514;
    localparam int IFG_BYTES_DEF = 12;

    // Framer state machine
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } framer_state_t;

endpackage

// File: rtl/ether_crc32_d8.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32.
// Purely combinational; the caller owns the CRC register.
module ether_crc32_d8
    import ether_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Shift the eight data bits through the CRC, LSB first
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/ether_gmii_tx_framer.sv
// GMII transmit framer: takes DA..payload bytes over valid/ready, adds
// preamble/SFD, optional padding, FCS, and enforces the inter-frame gap.
// Build option: ETHER_TX_PAD_EN enables padding of short frames to MIN_FRAME.
module ether_gmii_tx_framer
    import ether_pkg::*;
#(
    parameter int IFG_BYTES = IFG_BYTES_DEF,
    parameter int MAX_FRAME = MAX_FRAME_DEF
`ifdef ETHER_TX_PAD_EN
    // Only meaningful when padding is compiled in
    , parameter int MIN_FRAME = MIN_FRAME_DEF
`endif
) (
    input  logic        clk_125,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        phy_tx_en,
    output logic        phy_tx_er,
    output logic [7:0]  phy_tx_data,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
`ifdef ETHER_TX_PAD_EN
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
`endif
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

    framer_state_t state_reg;
    logic [31:0]   crc_reg;
    logic [10:0]   byte_cnt_reg;
    logic [2:0]    pre_cnt_reg;
    logic [1:0]    fcs_idx_reg;
    logic [15:0]   ifg_cnt_reg;
    logic          tx_en_reg;
    logic          tx_er_reg;
    logic [7:0]    tx_data_reg;
    logic [15:0]   frame_cnt_reg;
    logic [7:0]    err_cnt_reg;

    logic [7:0]    crc_data;
    logic [31:0]   crc_next;
    logic [7:0]    fcs_byte;
    logic [10:0]   byte_cnt_next;

    // Pad bytes are zeros; everything else feeds the CRC straight from the input
    assign crc_data      = (state_reg == ST_PAD) ? 8'h00 : s_data;
    assign byte_cnt_next = byte_cnt_reg + 11'd1;

    ether_crc32_d8 u_crc (
        .crc_in  (crc_reg),
        .data    (crc_data),
        .crc_out (crc_next)
    );

    // FCS goes out inverted, least significant byte first
    always_comb begin
        fcs_byte = 8'h00;
        case (fcs_idx_reg)
            2'd0:    fcs_byte = ~crc_reg[7:0];
            2'd1:    fcs_byte = ~crc_reg[15:8];
            2'd2:    fcs_byte = ~crc_reg[23:16];
            default: fcs_byte = ~crc_reg[31:24];
        endcase
    end

    // Upstream handshake depends on state only, never on s_valid
    assign s_ready     = (state_reg == ST_PAYLOAD) || (state_reg == ST_DROP);
    assign busy        = (state_reg != ST_IDLE);
    assign phy_tx_en   = tx_en_reg;
    assign phy_tx_er   = tx_er_reg;
    assign phy_tx_data = tx_data_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign err_cnt     = err_cnt_reg;

    // Framer FSM with registered GMII outputs and status counters
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            crc_reg       <= 32'hFFFF_FFFF;
            byte_cnt_reg  <= '0;
            pre_cnt_reg   <= '0;
            fcs_idx_reg   <= '0;
            ifg_cnt_reg   <= '0;
            tx_en_reg     <= 1'b0;
            tx_er_reg     <= 1'b0;
            tx_data_reg   <= 8'h00;
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else begin
            // Idle the line unless a state below drives it
            tx_en_reg   <= 1'b0;
            tx_er_reg   <= 1'b0;
            tx_data_reg <= 8'h00;

            case (state_reg)
                ST_IDLE: begin
                    // First preamble byte leaves on the cycle after s_valid is seen
                    if (s_valid) begin
                        state_reg    <= ST_PRE;
                        crc_reg      <= 32'hFFFF_FFFF;
                        byte_cnt_reg <= '0;
                        pre_cnt_reg  <= '0;
                        tx_en_reg    <= 1'b1;
                        tx_data_reg  <= PREAMBLE;
                    end
                end

                ST_PRE: begin
                    tx_en_reg <= 1'b1;
                    if (pre_cnt_reg == 3'd6) begin
                        tx_data_reg <= SFD;
                        state_reg   <= ST_PAYLOAD;
                    end else begin
                        tx_data_reg <= PREAMBLE;
                        pre_cnt_reg <= pre_cnt_reg + 3'd1;
                    end
                end

                ST_PAYLOAD: begin
                    if (!s_valid || (byte_cnt_reg == MAX_LEN)) begin
                        // Underrun or oversize: one error symbol, then abandon the frame
                        tx_en_reg   <= 1'b1;
                        tx_er_reg   <= 1'b1;
                        ifg_cnt_reg <= '0;
                        if (err_cnt_reg != 8'hFF) begin
                            err_cnt_reg <= err_cnt_reg + 8'd1;
                        end
                        if (s_valid && s_last) begin
                            state_reg <= ST_IFG;
                        end else begin
                            state_reg <= ST_DROP;
                        end
                    end else begin
                        tx_en_reg    <= 1'b1;
                        tx_data_reg  <= s_data;
                        crc_reg      <= crc_next;
                        byte_cnt_reg <= byte_cnt_next;
                        if (s_last) begin
                            fcs_idx_reg <= '0;
`ifdef ETHER_TX_PAD_EN
                            if (byte_cnt_next < MIN_LEN) begin
                                state_reg <= ST_PAD;
                            end else begin
                                state_reg <= ST_FCS;
                            end
`else
                            state_reg <= ST_FCS;
`endif
                        end
                    end
                end

`ifdef ETHER_TX_PAD_EN
                ST_PAD: begin
                    tx_en_reg    <= 1'b1;
                    crc_reg      <= crc_next;
                    byte_cnt_reg <= byte_cnt_next;
                    if (byte_cnt_next == MIN_LEN) begin
                        state_reg <= ST_FCS;
                    end
                end
`endif

                ST_FCS: begin
                    tx_en_reg   <= 1'b1;
                    tx_data_reg <= fcs_byte;
                    fcs_idx_reg <= fcs_idx_reg + 2'd1;
                    if (fcs_idx_reg == 2'd3) begin
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                        ifg_cnt_reg   <= '0;
                        state_reg     <= ST_IFG;
                    end
                end

                ST_DROP: begin
                    // Swallow the rest of an aborted frame
                    if (s_valid && s_last) begin
                        ifg_cnt_reg <= '0;
                        state_reg   <= ST_IFG;
                    end
                end

                ST_IFG: begin
                    if (ifg_cnt_reg == IFG_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        ifg_cnt_reg <= ifg_cnt_reg + 16'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ether_gmii_tx_framer.md
# ether_gmii_tx_framer

GMII transmit framer between clk_125 packet generators (UDP demo sender, ARP responder) and the PHY pins. Accepts a byte stream (destination MAC through last payload byte) over valid/ready. Prepends preamble/SFD, pads short frames, appends the Ethernet FCS and enforces the inter-frame gap. Generators no longer count bytes or compute CRC themselves.

## Interface
- IFG_BYTES, 12, idle cycles between the last FCS byte and the next preamble byte
- MIN_FRAME, 60, minimum DA-to-pad byte count, FCS excluded
- MAX_FRAME, 1514, maximum DA-to-payload byte count, FCS excluded
- clk_125  in  1  125 MHz clock; all logic is in this domain
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  upstream byte valid
- s_ready  out  1  upstream byte accepted when s_valid && s_ready
- s_data  in  8  frame byte
- s_last  in  1  marks the final byte of the frame
- phy_tx_en  out  1  GMII TX_EN, registered
- phy_tx_er  out  1  GMII TX_ER, registered
- phy_tx_data  out  8  GMII TXD, registered
- busy  out  1  state != IDLE
- frame_cnt  out  16  frames completed with FCS, wraps
- err_cnt  out  8  aborted frames, saturates at 255

## Operation
- Reset: phy_tx_en=0, phy_tx_er=0, phy_tx_data=0x00, s_ready=0, busy=0, counters 0, CRC register 0xFFFFFFFF, state IDLE.
- States: IDLE, PRE, PAYLOAD, PAD, FCS, DROP, IFG.
- IDLE: when s_valid=1, go to PRE; the CRC register is set to all ones.
- PRE: 8 cycles, loading 0x55 ×7 then 0xD5, with phy_tx_en=1. After the 0xD5 load, go to PAYLOAD.
- PAYLOAD: s_ready=1.
  - Each accepted byte loads phy_tx_data, updates the CRC and increments byte_cnt (11 bit).
  - On s_last: go to PAD if byte_cnt+1 < MIN_FRAME, else go to FCS.
- PAD: loads 0x00 (CRC updated) until byte_cnt reaches MIN_FRAME, then go to FCS.
- FCS: 4 cycles, loading ~crc[7:0], ~crc[15:8], ~crc[23:16], ~crc[31:24]. Then increment frame_cnt and go to IFG.
- CRC: reflected CRC-32 (0xEDB88320), LSB-first per byte, init all ones.
- IFG: phy_tx_en=0, phy_tx_data=0x00 for IFG_BYTES cycles, then IDLE.
- Underrun: in PAYLOAD with s_valid=0, load phy_tx_er=1, phy_tx_en=1, data 0x00 for one cycle. Then increment err_cnt and go to DROP.
- Oversize: accepting byte MAX_FRAME+1 without s_last takes the same path as underrun (that byte is replaced by the error cycle).
- DROP: phy_tx_en=0, s_ready=1. Discard bytes until s_last is accepted, then go to IFG.
  - If s_last arrived with the overflowing byte, go straight to IFG.
- s_ready is decoded from the state register only; there is no combinational path from s_valid.

## Timing
- Latency: a byte accepted in cycle N appears on phy_tx_data in cycle N+1.
- The first payload byte immediately follows 0xD5, with no gap.
- Frame start: s_valid seen in IDLE at cycle N → first 0x55 at N+1.
- Back-to-back: with s_valid held, exactly IFG_BYTES cycles of phy_tx_en=0 between frames.
- A minimum frame occupies 72 phy_tx_en cycles (8+60+4).
- Async reset mid-frame: outputs go to their reset values immediately. The partial frame is not resumed, and the first frame after release starts with preamble.

## Configuration
- ETHER_TX_PAD_EN
  - Defined: short frames are padded to MIN_FRAME as above.
  - Undefined: PAD state is removed; s_last always goes to FCS and short frames are sent unpadded.

## Structure
- Package ether_pkg holds:
  - PREAMBLE (0x55), SFD (0xD5)
  - CRC32_POLY_REFL (0xEDB88320)
  - CRC32_RESIDUE_REFL (0xDEBB20E3)
  - default MIN_FRAME/MAX_FRAME/IFG_BYTES
  - framer state enum
- Sub-module ether_crc32_d8: combinational next-CRC from (crc_in[31:0], data[7:0]). The framer owns the register.

## Test plan
- 60-byte frame (DA FF×6, rest 0xA5) → 0x55×7, 0xD5, 60 bytes, 4 FCS; phy_tx_en high 72 cycles. CRC over DA..FCS (init ones, no final xor) equals 0xDEBB20E3; frame_cnt=1.
- 14-byte frame with ETHER_TX_PAD_EN → 46×0x00 pad, phy_tx_en 72 cycles. Without the macro → phy_tx_en 26 cycles and valid FCS.
- Two 60-byte frames with s_valid held → exactly 12 cycles phy_tx_en=0 between them; frame_cnt=2.
- s_valid dropped before payload byte 21 → one cycle phy_tx_er=1/data 0x00, then phy_tx_en=0. The remaining bytes through s_last are drained; err_cnt=1, frame_cnt unchanged. The next frame starts after 12 idle cycles.
- 1600-byte stream without s_last until byte 1600 → phy_tx_er at byte position 1515, bytes up to 1600 drained, err_cnt=1.
- rst pulsed during payload byte 30 → all outputs 0 in the same cycle. After release, a new 60-byte frame transmits correctly.
